uart_transceiver_cfg: RTL and testbench

Full-duplex UART transceiver. Frame format (data bits, parity, stop bits) and baud rate are set at run time, not by elaboration parameters. TX accepts words on an AXI-Stream slave. RX returns words on an AXI-Stream master with per-word error flags (frame, parity, break) and an overrun pulse. It sits between host-side stream logic and the txd/rxd pins. It supersedes the fixed-format transceiver where one bitstream must serve several line formats.

---
 rtl/uart_transceiver_cfg.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_transceiver_cfg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver_cfg.sv
// Full-duplex UART with run-time frame format and baud rate. TX takes an AXI-Stream
// slave, RX drives an AXI-Stream master with {break, parity_err, frame_err} in tuser.
module uart_transceiver_cfg #(
    parameter int MAX_DATABITS = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             prescale,
    input  logic [3:0]              cfg_databits,
    input  logic [2:0]              cfg_parity,
    input  logic [1:0]              cfg_stopbits,
    input  logic [MAX_DATABITS-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [MAX_DATABITS-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [2:0]              m_axis_tuser,
    output logic                    rx_overrun,
    output logic                    txd,
    input  logic                    rxd,
    output logic                    tx_busy,
    output logic                    rx_busy
);
    localparam int CW = 20;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_st_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_st_t;

    logic [15:0]             w_ps;
    logic [CW-1:0]           w_t8, w_t4, w_tstop;
    logic [3:0]              w_nbits;
    logic [MAX_DATABITS-1:0] w_mask, w_tx_word;
    logic                    w_par_en, w_tx_par;

    assign w_ps = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_t8 = {1'b0, w_ps, 3'b000};
    assign w_t4 = {2'b00, w_ps, 2'b00};

    always_comb begin
        w_tstop = {w_ps, 4'b0000};
        if (cfg_stopbits == 2'd0)      w_tstop = w_t8;
        else if (cfg_stopbits == 2'd1) w_tstop = w_t8 + w_t4;
        w_nbits = cfg_databits;
        if (cfg_databits < 4'd5)                        w_nbits = 4'd5;
        else if (cfg_databits > 4'(MAX_DATABITS))       w_nbits = 4'(MAX_DATABITS);
        w_mask = '0;
        for (int i = 0; i < MAX_DATABITS; i++) w_mask[i] = (i < int'(w_nbits));
        w_tx_word = s_axis_tdata & w_mask;
        w_par_en  = (cfg_parity >= 3'd1) && (cfg_parity <= 3'd4);
        case (cfg_parity)
            3'd1:    w_tx_par = ~^w_tx_word;
            3'd2:    w_tx_par = ^w_tx_word;
            3'd3:    w_tx_par = 1'b1;
            default: w_tx_par = 1'b0;
        endcase
    end

    // ---------------- TX ----------------
    tx_st_t                  r_tx_state, w_tx_next;
    logic [CW-1:0]           r_tx_cnt, r_tx_t, r_tx_stop;
    logic [3:0]              r_tx_bit, r_tx_nbits;
    logic [MAX_DATABITS-1:0] r_tx_shift;
    logic                    r_tx_en, r_tx_par_en, r_tx_par;
    logic                    w_tx_tick, w_tx_acc;

    assign w_tx_tick     = (r_tx_cnt == '0);
    assign s_axis_tready = (r_tx_state == TX_IDLE) && r_tx_en;
    assign w_tx_acc      = s_axis_tready && s_axis_tvalid;
    assign tx_busy       = (r_tx_state != TX_IDLE);

    always_comb begin
        w_tx_next = r_tx_state;
        txd       = 1'b1;
        case (r_tx_state)
            TX_IDLE:  if (w_tx_acc) w_tx_next = TX_START;
            TX_START: begin
                txd = 1'b0;
                if (w_tx_tick) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                txd = r_tx_shift[0];
                if (w_tx_tick && (r_tx_bit == r_tx_nbits - 4'd1))
                    w_tx_next = r_tx_par_en ? TX_PAR : TX_STOP;
            end
            TX_PAR: begin
                txd = r_tx_par;
                if (w_tx_tick) w_tx_next = TX_STOP;
            end
            TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state  <= TX_IDLE;
            r_tx_en     <= 1'b0;
            r_tx_cnt    <= '0;
            r_tx_t      <= '0;
            r_tx_stop   <= '0;
            r_tx_bit    <= '0;
            r_tx_nbits  <= 4'd5;
            r_tx_shift  <= '0;
            r_tx_par_en <= 1'b0;
            r_tx_par    <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_en    <= 1'b1;
            if (w_tx_acc) begin
                r_tx_shift  <= w_tx_word;
                r_tx_nbits  <= w_nbits;
                r_tx_par_en <= w_par_en;
                r_tx_par    <= w_tx_par;
                r_tx_t      <= w_t8;
                r_tx_stop   <= w_tstop;
                r_tx_cnt    <= w_t8 - 20'd1;
                r_tx_bit    <= '0;
            end else if (r_tx_state != TX_IDLE) begin
                if (w_tx_tick) begin
                    r_tx_cnt <= (w_tx_next == TX_STOP) ? r_tx_stop - 20'd1 : r_tx_t - 20'd1;
                    if (r_tx_state == TX_DATA) begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= r_tx_bit + 4'd1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt - 20'd1;
                end
            end
        end
    end

    // ---------------- RX ----------------
    rx_st_t                  r_rx_state, w_rx_next;
    logic [1:0]              r_sync;
    logic                    r_rxs_prev;
    logic [CW-1:0]           r_rx_cnt, r_rx_t;
    logic [3:0]              r_rx_bit, r_rx_nbits;
    logic [2:0]              r_rx_pmode;
    logic [MAX_DATABITS-1:0] r_rx_data, r_m_data;
    logic [2:0]              r_m_user;
    logic                    r_rx_parbit, r_m_valid, r_ovr;
    logic                    w_rxs, w_fall, w_rx_tick, w_rx_pen, w_exp_par;
    logic                    w_ferr, w_perr, w_brk, w_stop_smp;

    assign w_rxs      = r_sync[1];
    assign w_fall     = r_rxs_prev && !w_rxs;
    assign w_rx_tick  = (r_rx_cnt == '0);
    assign w_rx_pen   = (r_rx_pmode >= 3'd1) && (r_rx_pmode <= 3'd4);
    assign w_stop_smp = (r_rx_state == RX_STOP) && w_rx_tick;
    assign w_ferr     = !w_rxs;
    assign w_perr     = w_rx_pen && (r_rx_parbit != w_exp_par);
    // A break is a stuck-low line: framing error with every sampled bit at 0.
    assign w_brk      = w_ferr && (r_rx_data == '0) && !(w_rx_pen && r_rx_parbit);
    assign rx_busy    = (r_rx_state != RX_IDLE);

    assign m_axis_tdata  = r_m_data;
    assign m_axis_tuser  = r_m_user;
    assign m_axis_tvalid = r_m_valid;
    assign rx_overrun    = r_ovr;

    always_comb begin
        case (r_rx_pmode)
            3'd1:    w_exp_par = ~^r_rx_data;
            3'd2:    w_exp_par = ^r_rx_data;
            3'd3:    w_exp_par = 1'b1;
            default: w_exp_par = 1'b0;
        endcase
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_fall) w_rx_next = RX_START;
            RX_START: if (w_rx_tick) w_rx_next = w_rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && (r_rx_bit == r_rx_nbits - 4'd1))
                          w_rx_next = w_rx_pen ? RX_PAR : RX_STOP;
            RX_PAR:   if (w_rx_tick) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = w_ferr ? RX_WAIT : RX_IDLE;
            RX_WAIT:  if (w_rxs) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_rxs_prev  <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_t      <= '0;
            r_rx_bit    <= '0;
            r_rx_nbits  <= 4'd5;
            r_rx_pmode  <= '0;
            r_rx_data   <= '0;
            r_rx_parbit <= 1'b0;
            r_m_data    <= '0;
            r_m_user    <= '0;
            r_m_valid   <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rxs_prev <= w_rxs;
            r_rx_state <= w_rx_next;
            if ((r_rx_state == RX_IDLE) && w_fall) begin
                r_rx_nbits  <= w_nbits;
                r_rx_pmode  <= cfg_parity;
                r_rx_t      <= w_t8;
                r_rx_cnt    <= w_t4 - 20'd1;
                r_rx_bit    <= '0;
                r_rx_data   <= '0;
                r_rx_parbit <= 1'b0;
            end else if ((r_rx_state != RX_IDLE) && (r_rx_state != RX_WAIT)) begin
                if (w_rx_tick) begin
                    r_rx_cnt <= r_rx_t - 20'd1;
                    if (r_rx_state == RX_DATA) begin
                        r_rx_data[r_rx_bit] <= w_rxs;
                        r_rx_bit            <= r_rx_bit + 4'd1;
                    end
                    if (r_rx_state == RX_PAR) r_rx_parbit <= w_rxs;
                end else begin
                    r_rx_cnt <= r_rx_cnt - 20'd1;
                end
            end
            // Output holding register: a word arriving while the previous one is stalled is dropped.
            r_ovr <= 1'b0;
            if (w_stop_smp) begin
                if (r_m_valid && !m_axis_tready) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_m_data  <= r_rx_data;
                    r_m_user  <= {w_brk, w_perr, w_ferr};
                    r_m_valid <= 1'b1;
                end
            end else if (r_m_valid && m_axis_tready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_transceiver_cfg.sv
// Scoreboard bench for uart_transceiver_cfg: loopback and hand-driven RX frames,
// error flags, overrun, glitch rejection and mid-frame reset.
module tb_uart_transceiver_cfg;
    logic       clk = 1'b0;
    logic       rst;
    logic [15:0] prescale;
    logic [3:0] cfg_databits;
    logic [2:0] cfg_parity;
    logic [1:0] cfg_stopbits;
    logic [8:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [8:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [2:0] m_axis_tuser;
    logic       rx_overrun, txd, rxd, tx_busy, rx_busy;
    logic       loop, drv;

    int n_vec = 0;
    int n_err = 0;
    logic [11:0] q[$];   // {tuser, data}

    assign rxd = loop ? txd : drv;

    always #5 clk = ~clk;

    uart_transceiver_cfg #(.MAX_DATABITS(9)) dut (
        .clk(clk), .rst(rst), .prescale(prescale),
        .cfg_databits(cfg_databits), .cfg_parity(cfg_parity), .cfg_stopbits(cfg_stopbits),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .rx_overrun(rx_overrun),
        .txd(txd), .rxd(rxd), .tx_busy(tx_busy), .rx_busy(rx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int db, input int par, input int sb, input int ps);
        cfg_databits = 4'(db);
        cfg_parity   = 3'(par);
        cfg_stopbits = 2'(sb);
        prescale     = 16'(ps);
    endtask

    task automatic send_tx(input logic [8:0] d);
        for (int n = 0; n < 3000 && !s_axis_tready; n++) @(negedge clk);
        if (!s_axis_tready) chk("tx_ready_timeout", s_axis_tready, 1);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    // Handshake, then sample txd at each bit centre and find the cycle tready returns.
    task automatic send_watch(input string tag, input logic [8:0] d, input int T, input int L,
                              output logic [15:0] obs, output int rdy_k);
        send_tx(d);
        obs   = '1;
        rdy_k = -1;
        for (int k = 1; k <= L + 20; k++) begin
            @(negedge clk);
            if ((k % T) == T / 2 && (k / T) < 16) obs[k / T] = txd;
            if (k == L)     chk({tag, "_busy_end"}, tx_busy, 1);
            if (k == L + 1) chk({tag, "_busy_off"}, tx_busy, 0);
            if (rdy_k < 0 && s_axis_tready) rdy_k = k;
        end
    endtask

    task automatic pop_word(input string tag, input int budget);
        logic [11:0] e;
        for (int n = 0; n < budget && !m_axis_tvalid; n++) @(negedge clk);
        if (!m_axis_tvalid) begin
            chk({tag, "_timeout"}, m_axis_tvalid, 1);
            return;
        end
        if (q.size() == 0) begin
            chk({tag, "_unexpected"}, q.size(), 1);
        end else begin
            e = q.pop_front();
            chk({tag, "_data"}, m_axis_tdata, e[8:0]);
            chk({tag, "_user"}, m_axis_tuser, e[11:9]);
        end
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1 m_axis_tready = 1'b0;
        @(negedge clk);
        chk({tag, "_clr"}, m_axis_tvalid, 0);
    endtask

    task automatic drive_bits(input logic [15:0] b, input int n, input int T);
        for (int i = 0; i < n; i++) begin
            drv = b[i];
            repeat (T) @(negedge clk);
        end
        drv = 1'b1;
    endtask

    int          tb_db[4]  = '{9, 5, 15, 2};
    int          tb_nb[4]  = '{9, 5, 9, 5};
    int          tb_par[4] = '{1, 3, 2, 4};
    int          tb_sb[4]  = '{1, 0, 3, 2};
    int          tb_ps[4]  = '{1, 3, 0, 2};

    initial begin
        logic [15:0] obs;
        logic [8:0]  d;
        int          rk, ovr;

        rst = 1'b1; loop = 1'b1; drv = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        set_cfg(8, 0, 0, 4);
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_ovr", rx_overrun, 0);
        chk("rst_busy", {tx_busy, rx_busy}, 0);
        rst = 1'b0;
        #1 chk("rel_tready0", s_axis_tready, 0);
        @(negedge clk);
        chk("rel_tready1", s_axis_tready, 1);

        // 8N1 loopback, 0xA5
        set_cfg(8, 0, 0, 4);
        q.push_back({3'b000, 9'h0A5});
        send_watch("a5", 9'h0A5, 32, 320, obs, rk);
        chk("a5_bits", obs[9:0], 10'h34A);
        chk("a5_rdy", rk, 321);
        pop_word("a5_rx", 2000);

        // 7E2, upper bits ignored
        set_cfg(7, 2, 2, 2);
        q.push_back({3'b000, 9'h053});
        send_watch("e7", 9'h1D3, 16, 176, obs, rk);
        chk("e7_bits", obs[10:0], 11'h6A6);
        chk("e7_rdy", rk, 177);
        pop_word("e7_rx", 2000);

        // assorted formats, clamped data widths, prescale 0
        for (int c = 0; c < 4; c++) begin
            set_cfg(tb_db[c], tb_par[c], tb_sb[c], tb_ps[c]);
            for (int w = 0; w < 2; w++) begin
                d = 9'($urandom_range(0, 511));
                q.push_back({3'b000, d & 9'((1 << tb_nb[c]) - 1)});
                send_tx(d);
                pop_word($sformatf("cfg%0d_w%0d", c, w), 3000);
            end
        end

        // 8O1 hand-driven 0x00 with wrong parity bit 0
        loop = 1'b0;
        set_cfg(8, 1, 0, 4);
        @(negedge clk);
        q.push_back({3'b010, 9'h000});
        drive_bits(16'h0400, 11, 32);
        pop_word("perr", 500);

        // break: line low for 12 bit times
        set_cfg(8, 0, 0, 4);
        q.push_back({3'b101, 9'h000});
        drv = 1'b0;
        repeat (360) @(negedge clk);
        chk("brk_wait_busy", rx_busy, 1);
        repeat (24) @(negedge clk);
        drv = 1'b1;
        pop_word("brk", 100);
        repeat (10) @(negedge clk);
        chk("brk_idle", rx_busy, 0);
        repeat (500) @(negedge clk);
        chk("brk_no_second", m_axis_tvalid, 0);

        // glitch: low for 2*prescale
        drv = 1'b0;
        repeat (6) @(negedge clk);
        chk("gl_busy", rx_busy, 1);
        repeat (2) @(negedge clk);
        drv = 1'b1;
        repeat (22) @(negedge clk);
        chk("gl_idle", rx_busy, 0);
        repeat (400) @(negedge clk);
        chk("gl_no_word", m_axis_tvalid, 0);

        // overrun: tready held low over two frames
        loop = 1'b1;
        q.push_back({3'b000, 9'h011});
        send_tx(9'h011);
        send_tx(9'h022);
        ovr = 0;
        repeat (400) begin
            @(negedge clk);
            ovr += int'(rx_overrun);
        end
        chk("ovr_pulses", ovr, 1);
        pop_word("ovr_keep", 10);

        // reset mid-TX
        send_tx(9'h000);
        repeat (100) @(negedge clk);
        chk("mid_txd_low", txd, 0);
        rst = 1'b1;
        #1 chk("rst_txd_async", txd, 1);
        chk("rst_mid_busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_rel_tready0", s_axis_tready, 0);
        @(negedge clk);
        chk("mid_rel_tready1", s_axis_tready, 1);
        repeat (400) @(negedge clk);
        chk("mid_rx_discard", m_axis_tvalid, 0);
        chk("sb_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
